// File: rtl/ecall_stream_arbiter.sv
// rtl/ecall_stream_arbiter.sv - port-B reader streaming bytes to the Arduino link for CPU/debug requesters
// Optional build macro: ECALL_STREAM_CHECKSUM_EN appends an XOR checksum handshake after the data bytes.
module ecall_stream_arbiter #(
    parameter int ADDR_W  = 12,
    parameter int LEN_W   = 16,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 50000
) (
    input  logic              ADC_CLK_10,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [LEN_W-1:0]  cpu_len,
    output logic              cpu_done,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [LEN_W-1:0]  dbg_len,
    output logic              dbg_done,
    output logic              mem_rden,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [63:0]       mem_q,
    output logic [7:0]        ard_data,
    output logic              ard_strobe,
    input  logic              ard_ack,
    output logic              busy,
    output logic              owner,
    output logic              timeout_err
);

    localparam int SW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_SETTLE,
        S_ACK_HI,
        S_ACK_LO,
        S_FINISH
`ifdef ECALL_STREAM_CHECKSUM_EN
        , S_SUM
`endif
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] base;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  ptr;
    logic [LEN_W-1:0]  ptr_inc;
    logic [SW-1:0]     settle_cnt;
    logic [TW-1:0]     phase_cnt;
    logic              ack_meta;
    logic              ack_s;
    logic              cpu_armed;
    logic              cpu_elig;
    logic              grant;
    logic              grant_dbg;
    logic [LEN_W-1:0]  grant_len;
    logic              last_byte;
    logic              phase_expired;
    logic              timeout_hit;
    logic              unused_q;
`ifdef ECALL_STREAM_CHECKSUM_EN
    logic [7:0]        csum;
    logic              sum_sent;
`endif

    // Round-robin: on contention the requester that did not own the last grant wins.
    assign cpu_elig      = cpu_req & cpu_armed;
    assign grant         = cpu_elig | dbg_req;
    assign grant_dbg     = dbg_req & (~cpu_elig | ~owner);
    assign grant_len     = grant_dbg ? dbg_len : cpu_len;
    assign ptr_inc       = ptr + 1'b1;
    assign last_byte     = (ptr_inc == len_q);
    assign phase_expired = (phase_cnt == TW'(TIMEOUT - 1));
    assign unused_q      = ^mem_q[63:8];

    assign mem_rden = (state == S_READ);
    assign mem_addr = mem_rden ? (base + ADDR_W'(ptr)) : '0;

    always_ff @(posedge ADC_CLK_10 or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant) begin
                    if (grant_len == '0) begin
`ifdef ECALL_STREAM_CHECKSUM_EN
                        state_next = S_SUM;
`else
                        state_next = S_FINISH;
`endif
                    end else begin
                        state_next = S_READ;
                    end
                end
            end
            S_READ:    state_next = S_CAPTURE;
            S_CAPTURE: state_next = S_SETTLE;
            S_SETTLE: begin
                if (settle_cnt <= SW'(1)) begin
                    state_next = S_ACK_HI;
                end
            end
            S_ACK_HI: begin
                if (ack_s) begin
                    state_next = S_ACK_LO;
                end else if (phase_expired) begin
                    state_next  = S_FINISH;
                    timeout_hit = 1'b1;
                end
            end
            S_ACK_LO: begin
                if (!ack_s) begin
`ifdef ECALL_STREAM_CHECKSUM_EN
                    if (sum_sent) begin
                        state_next = S_FINISH;
                    end else if (last_byte) begin
                        state_next = S_SUM;
                    end else begin
                        state_next = S_READ;
                    end
`else
                    state_next = last_byte ? S_FINISH : S_READ;
`endif
                end else if (phase_expired) begin
                    state_next  = S_FINISH;
                    timeout_hit = 1'b1;
                end
            end
            S_FINISH: state_next = S_IDLE;
`ifdef ECALL_STREAM_CHECKSUM_EN
            S_SUM:    state_next = S_SETTLE;
`endif
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ADC_CLK_10 or posedge rst) begin
        if (rst) begin
            ack_meta    <= 1'b0;
            ack_s       <= 1'b0;
            base        <= '0;
            len_q       <= '0;
            ptr         <= '0;
            settle_cnt  <= '0;
            phase_cnt   <= '0;
            cpu_armed   <= 1'b0;
            cpu_done    <= 1'b1;
            dbg_done    <= 1'b0;
            ard_data    <= 8'h00;
            ard_strobe  <= 1'b0;
            busy        <= 1'b0;
            owner       <= 1'b0;
            timeout_err <= 1'b0;
`ifdef ECALL_STREAM_CHECKSUM_EN
            csum        <= 8'h00;
            sum_sent    <= 1'b0;
`endif
        end else begin
            ack_meta   <= ard_ack;
            ack_s      <= ack_meta;
            dbg_done   <= 1'b0;
            ard_strobe <= (state_next == S_ACK_HI);
            if (!cpu_req) begin
                cpu_armed <= 1'b1;
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
            // The ack watchdog restarts on every state change, so each edge gets a full budget.
            if (state_next != state) begin
                phase_cnt <= '0;
            end else if (state == S_ACK_HI || state == S_ACK_LO) begin
                phase_cnt <= phase_cnt + 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (grant) begin
                        base  <= grant_dbg ? dbg_addr : cpu_addr;
                        len_q <= grant_len;
                        ptr   <= '0;
                        busy  <= 1'b1;
                        owner <= grant_dbg;
                        if (!grant_dbg) begin
                            cpu_done  <= 1'b0;
                            cpu_armed <= 1'b0;
                        end
`ifdef ECALL_STREAM_CHECKSUM_EN
                        csum     <= 8'h00;
                        sum_sent <= 1'b0;
`endif
                    end
                end
                S_CAPTURE: begin
                    ard_data   <= mem_q[7:0];
                    settle_cnt <= SW'(SETTLE);
`ifdef ECALL_STREAM_CHECKSUM_EN
                    csum       <= csum ^ mem_q[7:0];
`endif
                end
                S_SETTLE: settle_cnt <= settle_cnt - 1'b1;
                S_ACK_LO: begin
                    if (!ack_s) begin
                        ptr <= ptr_inc;
                    end
                end
`ifdef ECALL_STREAM_CHECKSUM_EN
                S_SUM: begin
                    ard_data   <= csum;
                    settle_cnt <= SW'(SETTLE);
                    sum_sent   <= 1'b1;
                end
`endif
                S_FINISH: begin
                    busy     <= 1'b0;
                    ard_data <= 8'h00;
                    if (owner) begin
                        dbg_done <= 1'b1;
                    end else begin
                        cpu_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ecall_stream_arbiter.sv
// tb/tb_ecall_stream_arbiter.sv - scoreboard bench for ecall_stream_arbiter
`timescale 1ns/1ps
module tb_ecall_stream_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [11:0] cpu_addr;
    logic [15:0] cpu_len;
    logic        cpu_done;
    logic        dbg_req;
    logic [11:0] dbg_addr;
    logic [15:0] dbg_len;
    logic        dbg_done;
    logic        mem_rden;
    logic [11:0] mem_addr;
    logic [63:0] mem_q;
    logic [7:0]  ard_data;
    logic        ard_strobe;
    logic        ard_ack;
    logic        busy;
    logic        owner;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;

    logic [63:0] mem [0:4095];
    logic [2:0]  ack_sr = 3'b000;
    logic        ack_en;

    logic [7:0]  exp_data [$];
    logic [11:0] exp_addr [$];
    logic        exp_evt  [$];

    ecall_stream_arbiter #(
        .ADDR_W(12), .LEN_W(16), .SETTLE(2), .TIMEOUT(100)
    ) dut (
        .ADC_CLK_10(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_len(cpu_len), .cpu_done(cpu_done),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_len(dbg_len), .dbg_done(dbg_done),
        .mem_rden(mem_rden), .mem_addr(mem_addr), .mem_q(mem_q),
        .ard_data(ard_data), .ard_strobe(ard_strobe), .ard_ack(ard_ack),
        .busy(busy), .owner(owner), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Memory returns data one cycle after the read; garbage otherwise.
    always @(posedge clk) begin
        mem_q  <= mem_rden ? mem[mem_addr] : 64'hFFFF_FFFF_FFFF_FFFF;
        ack_sr <= {ack_sr[1:0], ard_strobe};
    end
    assign ard_ack = ack_en & ack_sr[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event expected none", name);
    endtask

    logic prev_strobe = 1'b0;
    logic prev_cpu_done = 1'b1;

    always @(negedge clk) begin
        if (rst) begin
            prev_strobe   = ard_strobe;
            prev_cpu_done = cpu_done;
        end else begin
            if (ard_strobe && !prev_strobe) begin
                if (exp_data.size() == 0) fail("unexpected_strobe");
                else chk("strobe_data", ard_data, exp_data.pop_front());
            end
            if (mem_rden) begin
                if (exp_addr.size() == 0) fail("unexpected_read");
                else chk("mem_addr", mem_addr, exp_addr.pop_front());
            end
            if (cpu_done && !prev_cpu_done) begin
                if (exp_evt.size() == 0) fail("unexpected_cpu_done");
                else chk("done_cpu", 1'b0, exp_evt.pop_front());
                chk("owner_at_cpu_done", owner, 1'b0);
            end
            if (dbg_done) begin
                if (exp_evt.size() == 0) fail("unexpected_dbg_done");
                else chk("done_dbg", 1'b1, exp_evt.pop_front());
                chk("owner_at_dbg_done", owner, 1'b1);
            end
            prev_strobe   = ard_strobe;
            prev_cpu_done = cpu_done;
        end
    end

    task automatic expect_xfer(input logic [11:0] addr, input int len, input logic who);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        for (int i = 0; i < len; i++) begin
            exp_addr.push_back(addr + 12'(i));
            b = mem[addr + 12'(i)][7:0];
            exp_data.push_back(b);
            x = x ^ b;
        end
`ifdef ECALL_STREAM_CHECKSUM_EN
        exp_data.push_back(x);
`endif
        exp_evt.push_back(who);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_data.size() != 0 || exp_evt.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) fail({name, "_timeout"});
    endtask

    task automatic wait_strobe(input string name);
        int n;
        n = 0;
        while (!ard_strobe && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail({name, "_no_strobe"});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int hi;
        for (int i = 0; i < 4096; i++) mem[i] = {56'hA5A5_5A5A_C3C3_3C, 8'(i * 7)};
        mem[12'h100] = 64'h1111_2222_3333_4448;
        mem[12'h101] = 64'hFFFF_0000_FFFF_0069;
        mem[12'h102] = 64'h0123_4567_89AB_CD0A;
        mem[12'h200] = 64'h0000_0000_0000_0011;
        mem[12'h201] = 64'h0000_0000_0000_0022;
        mem[12'h300] = 64'h0000_0000_0000_0033;
        mem[12'hFFF] = 64'h0000_0000_0000_00A5;
        mem[12'h000] = 64'h0000_0000_0000_005A;
        mem[12'h010] = 64'h0000_0000_0000_0077;
        mem[12'h011] = 64'h0000_0000_0000_0099;
        mem[12'h020] = 64'h0000_0000_0000_0042;
        mem[12'h021] = 64'h0000_0000_0000_003C;
        rst = 1'b1; ack_en = 1'b1;
        cpu_req = 1'b0; cpu_addr = '0; cpu_len = '0;
        dbg_req = 1'b0; dbg_addr = '0; dbg_len = '0;
        idle(3);
        chk("rst_cpu_done", cpu_done, 1'b1);
        chk("rst_dbg_done", dbg_done, 1'b0);
        chk("rst_mem_rden", mem_rden, 1'b0);
        chk("rst_mem_addr", mem_addr, 12'h000);
        chk("rst_ard_data", ard_data, 8'h00);
        chk("rst_strobe", ard_strobe, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_owner", owner, 1'b0);
        chk("rst_timeout_err", timeout_err, 1'b0);
        rst = 1'b0;
        idle(3);

        // CPU streams three bytes
        expect_xfer(12'h100, 3, 1'b0);
        cpu_addr = 12'h100; cpu_len = 16'd3; cpu_req = 1'b1;
        idle(5);
        chk("cpu_done_low_active", cpu_done, 1'b0);
        chk("busy_active", busy, 1'b1);
        wait_done("cpu3");
        chk("cpu_done_after", cpu_done, 1'b1);
        chk("ard_data_cleared", ard_data, 8'h00);
        idle(40);
        chk("no_retrigger_busy", busy, 1'b0);
        cpu_req = 1'b0;
        idle(2);

        // Zero-length request
        expect_xfer(12'h000, 0, 1'b0);
        cpu_addr = 12'h000; cpu_len = 16'd0; cpu_req = 1'b1;
`ifndef ECALL_STREAM_CHECKSUM_EN
        idle(1);
        chk("len0_cpu_done_low", cpu_done, 1'b0);
        idle(2);
        chk("len0_cpu_done_back", cpu_done, 1'b1);
`endif
        wait_done("len0");
        idle(20);
        chk("len0_no_second", busy, 1'b0);
        cpu_req = 1'b0;
        idle(2);

        // Contention: debug first, then CPU
        chk("owner_before_contention", owner, 1'b0);
        expect_xfer(12'h200, 2, 1'b1);
        expect_xfer(12'h300, 1, 1'b0);
        dbg_addr = 12'h200; dbg_len = 16'd2;
        cpu_addr = 12'h300; cpu_len = 16'd1;
        cpu_req = 1'b1; dbg_req = 1'b1;
        idle(2);
        chk("contention_owner_dbg", owner, 1'b1);
        hi = 0;
        while (!dbg_done && hi < 3000) begin @(negedge clk); hi++; end
        if (hi >= 3000) fail("contention_no_dbg_done");
        dbg_req = 1'b0;
        wait_done("contention");
        chk("contention_owner_cpu", owner, 1'b0);
        cpu_req = 1'b0;
        idle(2);

        // Address wrap
        expect_xfer(12'hFFF, 2, 1'b0);
        cpu_addr = 12'hFFF; cpu_len = 16'd2; cpu_req = 1'b1;
        wait_done("wrap");
        cpu_req = 1'b0;
        idle(2);

        // Ack stuck low: timeout
        ack_en = 1'b0;
        exp_addr.push_back(12'h010);
        exp_data.push_back(8'h77);
        exp_evt.push_back(1'b0);
        cpu_addr = 12'h010; cpu_len = 16'd1; cpu_req = 1'b1;
        wait_strobe("timeout");
        hi = 0;
        while (ard_strobe && hi < 300) begin @(negedge clk); hi++; end
        chk("timeout_strobe_cycles", hi, 100);
        wait_done("timeout");
        chk("timeout_err_set", timeout_err, 1'b1);
        chk("timeout_cpu_done", cpu_done, 1'b1);
        ack_en = 1'b1;
        cpu_req = 1'b0;
        idle(5);
        expect_xfer(12'h011, 1, 1'b0);
        cpu_addr = 12'h011; cpu_len = 16'd1; cpu_req = 1'b1;
        wait_done("after_timeout");
        chk("timeout_err_sticky", timeout_err, 1'b1);
        cpu_req = 1'b0;
        idle(2);

        // Reset in ACK_HI
        ack_en = 1'b0;
        exp_addr.push_back(12'h020);
        exp_data.push_back(8'h42);
        cpu_addr = 12'h020; cpu_len = 16'd1; cpu_req = 1'b1;
        wait_strobe("reset_mid");
        idle(5);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_strobe", ard_strobe, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_cpu_done", cpu_done, 1'b1);
        chk("rst_mid_timeout_err", timeout_err, 1'b0);
        cpu_req = 1'b0; ack_en = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(3);
        chk("post_rst_idle_busy", busy, 1'b0);
        chk("post_rst_no_read", mem_rden, 1'b0);
        expect_xfer(12'h021, 1, 1'b0);
        cpu_addr = 12'h021; cpu_len = 16'd1; cpu_req = 1'b1;
        wait_done("post_rst");
        cpu_req = 1'b0;
        idle(5);

        chk("left_data", exp_data.size(), 0);
        chk("left_addr", exp_addr.size(), 0);
        chk("left_evt", exp_evt.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
